// File: rtl/cnn_pkg.sv
// cnn_pkg: shared widths and drain FSM states for the CNN result-buffer reader.
package cnn_pkg;
    localparam int DEF_RESULT_BUFFER_WIDTH = 16;
    localparam int DEF_COUNT_WIDTH = 7;
    localparam int DEF_CHECKSUM_WIDTH = 24;
    typedef enum logic [1:0] {IDLE, REQ, FLUSH, FINISH} drain_state_t;
endpackage

// File: rtl/result_drain_if.sv
// result_drain_if: CNN result-buffer read port plus the valid/ready output stream.
interface result_drain_if import cnn_pkg::*; #(parameter int W = DEF_RESULT_BUFFER_WIDTH);
    logic [W-1:0] result_buffer_out;
    logic result_buffer_valid;
    logic result_buffer_empty;
    logic result_buffer_read_enable;
    logic [W-1:0] out_data;
    logic out_valid;
    logic out_ready;
    modport master(
        input result_buffer_out, result_buffer_valid, result_buffer_empty, out_ready,
        output result_buffer_read_enable, out_data, out_valid
    );
    modport slave(
        output result_buffer_out, result_buffer_valid, result_buffer_empty, out_ready,
        input result_buffer_read_enable, out_data, out_valid
    );
endinterface

// File: rtl/result_drain_fifo2.sv
// result_drain_fifo2: 2-entry register FIFO, head word driven straight from a register.
module result_drain_fifo2 import cnn_pkg::*; #(parameter int W = DEF_RESULT_BUFFER_WIDTH) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] mem1;
    logic [1:0] cnt;
    logic do_pop;
    assign do_pop = pop && cnt != 2'd0;
    assign full = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout <= '0;
            mem1 <= '0;
            cnt <= '0;
        end else begin
            cnt <= cnt + 2'(push) - 2'(do_pop);
            // Head takes the new word when it would otherwise be empty, else shifts up from the tail.
            if (push && (cnt == 2'd0 || (do_pop && cnt == 2'd1)))
                dout <= din;
            else if (do_pop && cnt == 2'd2)
                dout <= mem1;
            if (push && ((cnt == 2'd1 && !do_pop) || (cnt == 2'd2 && do_pop)))
                mem1 <= din;
        end
    end
endmodule

// File: rtl/result_drain.sv
// result_drain: drains a programmed number of psums from the CNN result buffer into a
// valid/ready stream, keeping a running checksum and pulsing done at job end.
module result_drain import cnn_pkg::*; #(
    parameter int RESULT_BUFFER_WIDTH = DEF_RESULT_BUFFER_WIDTH,
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int CHECKSUM_WIDTH = DEF_CHECKSUM_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [COUNT_WIDTH-1:0]    drain_count,
    result_drain_if.master            bus,
    output logic                      busy,
    output logic                      done,
    output logic [CHECKSUM_WIDTH-1:0] checksum
);
    drain_state_t state, state_n;
    logic [COUNT_WIDTH-1:0] remaining;
    logic read_enable, accept, pop, full, fifo_empty, start_ok, issue;
    assign accept = read_enable && bus.result_buffer_valid;
    assign pop = bus.out_valid && bus.out_ready;
    assign start_ok = state == IDLE && start;
    assign bus.out_valid = !fifo_empty;
    assign bus.result_buffer_read_enable = read_enable;
    // A request may only go out if its word is guaranteed a FIFO slot after this cycle's pop.
    assign issue = (state == REQ || (start_ok && drain_count != '0))
                   && !bus.result_buffer_empty && (!full || pop);
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:   state_n = start ? (drain_count == '0 ? FINISH : REQ) : IDLE;
            REQ:    state_n = (accept && remaining == COUNT_WIDTH'(1)) ? FLUSH : REQ;
            FLUSH:  state_n = fifo_empty ? FINISH : FLUSH;
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            read_enable <= 1'b0;
            remaining <= '0;
            checksum <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            read_enable <= read_enable ? !bus.result_buffer_valid : issue;
            done <= state == FINISH;
            busy <= start_ok ? 1'b1 : (state == FINISH ? 1'b0 : busy);
            if (start_ok) begin
                remaining <= drain_count;
                checksum <= '0;
            end else if (accept) begin
                remaining <= remaining - COUNT_WIDTH'(1);
                checksum <= checksum + CHECKSUM_WIDTH'(bus.result_buffer_out);
            end
        end
    end
    result_drain_fifo2 #(.W(RESULT_BUFFER_WIDTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(accept),
        .pop(pop),
        .din(bus.result_buffer_out),
        .dout(bus.out_data),
        .full(full),
        .empty(fifo_empty)
    );
endmodule
